devtbl_multi: RTL and testbench
===============================

# devtbl_multi

Parametrised device-table and SoC-control slave on the pi1 bus. It returns a DEVCNT-entry device table to software. It answers system queries: version, cache size, reset state, preloader address, counts. It drives a CORECNT-wide per-core reset vector with hold, release and timed-pulse commands. It is the next generation of the fixed five-entry, two-core table. It sits behind the pi1 interconnect at the device-table window, and its reset outputs feed each core's reset input.

## Interface
- ARCHBITSZ, 32: bus data width; the address is ARCHBITSZ-clog2(ARCHBITSZ/8) bits.
- DEVCNT, 5: number of device-table entries (1..64).
- DEVTBLINIT, 0: packed DEVCNT*2*ARCHBITSZ bits.
  - Entry i, low word: device id.
  - Entry i, high word: {mapsz, 2-bit flags}, pre-formatted.
- CORECNT, 2: number of per-core reset outputs (1..ARCHBITSZ-2).
- RSTINIT, 0: CORECNT-bit value of rst_o under rst_i.
- RSTPULSECNT, 16: cycles a pulse command holds reset (>=1).
- MAPSZ, 892: value driven on pi1_mapsz_o.
- SOCVERSION, RAMCACHESZ, PRELDRADDR: 0, 0, 0; query constants.
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- rst_o  out  CORECNT  per-core reset requests.
- preldr_o  out  1  single-cycle pulse on the preloader-disable command.
- pi1_op_i  in  2  00 noop, 01 write, 10 read, 11 read-write.
- pi1_addr_i  in  ADDRBITSZ  word address.
- pi1_data_i  in  ARCHBITSZ  write/query data.
- pi1_data_o  out  ARCHBITSZ  registered read data.
- pi1_sel_i  in  ARCHBITSZ/8  byte enables.
- pi1_rdy_o  out  1  request accepted this cycle.
- pi1_mapsz_o  out  ADDRBITSZ  constant MAPSZ.

## Operation
- **Read (10).**
  - addr 2i returns the id of entry i; addr 2i+1 returns its {mapsz, flags} word, for i<DEVCNT.
  - Any other addr returns 0.
- **Read-write at addr 0 (query).** Selected by data_i:
  - 0: SOCVERSION. 1: RAMCACHESZ. 2: zero-extended rst_o.
  - 3: PRELDRADDR, or 0 once disabled. 4: DEVCNT. 5: CORECNT.
  - Anything else: 0.
- **Read-write at addr 1 (command).**
  - Command code is data_i[ARCHBITSZ-1:ARCHBITSZ-2]; the core mask is data_i[CORECNT-1:0].
  - 0, HOLD: rst_o |= mask.
  - 1, RELEASE: rst_o &= ~mask.
  - 2, PULSE: rst_o |= mask, FSM goes to PULSE.
  - 3, PRELDR: set the sticky preldr_dis flag and pulse preldr_o.
  - Commands always return data_o = 0.
  - Commands with pi1_sel_i not all ones are ignored; data_o is still 0.
- **Write (01) and noop.** No effect; data_o is held.
- **Reset FSM.**
  - IDLE: rdy_o=1; a PULSE command loads cnt=RSTPULSECNT-1 and moves to PULSE.
  - PULSE: rdy_o=0; cnt decrements each cycle. At cnt==0, rst_o &= ~pmask (the latched pulse mask) and the FSM returns to IDLE.
  - Cores not in pmask keep their state through the pulse.
- **Reset values (rst_i).** rst_o=RSTINIT, preldr_dis=0, preldr_o=0, data_o=0, FSM=IDLE, cnt=0.
- **rst_i asserted mid-pulse** aborts the pulse immediately: rst_o=RSTINIT.
- **PULSE with an empty mask** still enters PULSE for RSTPULSECNT cycles.

## Timing
- pi1_data_o is valid on the cycle after a read or read-write accepted with rdy_o=1. Latency is 1.
- Back-to-back requests are accepted every cycle in IDLE.
- rst_o updates on the clock edge after a HOLD or RELEASE is accepted.
- A PULSE is accepted at edge T:
  - rst_o bits go high at T+1.
  - rdy_o is low from T+1 to T+RSTPULSECNT.
  - Released bits go low at T+RSTPULSECNT+1, when rdy_o returns high.
- preldr_o is high exactly during the cycle after the PRELDR command; it is registered.
- Requests presented while rdy_o=0 are ignored, and data_o is held. The master must retry.
- cnt width is clog2(RSTPULSECNT+1). There is no wrap-around, because the counter stops at 0.

## Configuration
- DEVTBL_PRELDR_EN defined:
  - query 3 and command 3 behave as above.
  - preldr_o is driven.
- DEVTBL_PRELDR_EN undefined:
  - query 3 returns 0.
  - command 3 is a no-op returning 0.
  - preldr_o is tied 0, and the preldr_dis flag is not built.

## Structure
- The shared package devtbl_pkg holds:
  - op codes PINOOP/PIWROP/PIRDOP/PIRWOP;
  - command codes CMD_HOLD/CMD_RELEASE/CMD_PULSE/CMD_PRELDR;
  - query selectors QRY_VERSION..QRY_CORECNT;
  - FSM state encoding IDLE/PULSE.
- Sub-module devtbl_rstctl contains the reset FSM, pulse counter, pmask and rst_o register. It exposes busy, which the top inverts to form rdy_o.
- The top holds table decode, query mux, preldr logic and the data_o register.

## Test plan
- Read addr 0..2*DEVCNT+1 with DEVCNT=5 → ids/words from DEVTBLINIT one cycle later; addr 10 and 11 → 0.
- Query sequence data_i = 0, 1, 4, 5, 9 at addr 1-read-write... at addr 0 → SOCVERSION, RAMCACHESZ, 5, 2, 0.
- HOLD with mask 2'b10, then query 2 → 2; RELEASE with mask 2'b10 → query 2 returns 0.
- PULSE with mask 2'b01, RSTPULSECNT=16 → rst_o[0] high for 16 cycles and rdy_o low for 16 cycles. A read issued mid-pulse is ignored, and data_o is held.
- PRELDR with PRELDRADDR=0x1000 → preldr_o is a 1-cycle pulse, and query 3 changes from 0x1000 to 0. With the macro undefined, it stays 0 and preldr_o never rises.
- Assert rst_i at cycle 5 of a pulse → rst_o=RSTINIT and rdy_o=1 immediately, with no pending release afterwards.

Source files
------------

// File: rtl/devtbl_pkg.sv
// devtbl_pkg: shared bus op, command, query and reset-FSM encodings for devtbl_multi
package devtbl_pkg;
  typedef enum logic [1:0] {PINOOP, PIWROP, PIRDOP, PIRWOP} op_e;
  typedef enum logic [1:0] {CMD_HOLD, CMD_RELEASE, CMD_PULSE, CMD_PRELDR} cmd_e;
  typedef enum logic [2:0] {QRY_VERSION, QRY_CACHESZ, QRY_RSTO, QRY_PRELDR, QRY_DEVCNT, QRY_CORECNT} qry_e;
  typedef enum logic {IDLE, PULSE} state_e;
endpackage

// File: rtl/devtbl_rstctl.sv
// devtbl_rstctl: per-core reset register with hold/release commands and a timed pulse FSM
module devtbl_rstctl
  import devtbl_pkg::*;
#(
  parameter int CORECNT = 2,
  parameter logic [CORECNT-1:0] RSTINIT = '0,
  parameter int RSTPULSECNT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_vld,
  input  logic [1:0]         i_cmd,
  input  logic [CORECNT-1:0] i_mask,
  output logic [CORECNT-1:0] o_rst,
  output logic               o_busy
);
  localparam int CW = $clog2(RSTPULSECNT + 1);
  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [CORECNT-1:0] r_pmask;
  logic [CORECNT-1:0] r_rst;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pmask <= '0;
      r_rst   <= RSTINIT;
    end else if (r_state == PULSE) begin
      if (r_cnt == '0) begin
        r_rst   <= r_rst & ~r_pmask;
        r_state <= IDLE;
      end else r_cnt <= r_cnt - 1'b1;
    end else if (i_vld) begin
      if (i_cmd == CMD_HOLD || i_cmd == CMD_PULSE) r_rst <= r_rst | i_mask;
      if (i_cmd == CMD_RELEASE) r_rst <= r_rst & ~i_mask;
      if (i_cmd == CMD_PULSE) begin
        r_pmask <= i_mask;
        r_cnt   <= CW'(RSTPULSECNT - 1);
        r_state <= PULSE;
      end
    end
  assign o_rst  = r_rst;
  assign o_busy = r_state == PULSE;
endmodule

// File: rtl/devtbl_multi.sv
// devtbl_multi: pi1 device-table, system-query and per-core reset control slave.
// Optional preloader-disable feature is built when DEVTBL_PRELDR_EN is defined.
module devtbl_multi
  import devtbl_pkg::*;
#(
  parameter int ARCHBITSZ = 32,
  parameter int DEVCNT = 5,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8),
  parameter logic [DEVCNT*2*ARCHBITSZ-1:0] DEVTBLINIT = '0,
  parameter int CORECNT = 2,
  parameter logic [CORECNT-1:0] RSTINIT = '0,
  parameter int RSTPULSECNT = 16,
  parameter int MAPSZ = 892,
  parameter logic [ARCHBITSZ-1:0] SOCVERSION = '0,
  parameter logic [ARCHBITSZ-1:0] RAMCACHESZ = '0,
  parameter logic [ARCHBITSZ-1:0] PRELDRADDR = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [CORECNT-1:0]     rst_o,
  output logic                   preldr_o,
  input  logic [1:0]             pi1_op_i,
  input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
  output logic                   pi1_rdy_o,
  output logic [ADDRBITSZ-1:0]   pi1_mapsz_o
);
  localparam int NW = 2 * DEVCNT;
  localparam int IW = $clog2(NW);
  logic [ARCHBITSZ-1:0] w_tbl [NW];
  logic                 w_busy, w_rd, w_cmd_vld, w_qhi;
  logic [2:0]           w_qsel;
  logic [ARCHBITSZ-1:0] w_pre, w_qry, w_rdata;
  logic [ARCHBITSZ-1:0] r_data;
  for (genvar i = 0; i < NW; i++) begin : g_tbl
    assign w_tbl[i] = DEVTBLINIT[i*ARCHBITSZ +: ARCHBITSZ];
  end
  assign pi1_rdy_o   = ~w_busy;
  assign pi1_mapsz_o = ADDRBITSZ'(MAPSZ);
  assign pi1_data_o  = r_data;
  assign w_rd        = pi1_rdy_o && (pi1_op_i == PIRDOP || pi1_op_i == PIRWOP);
  assign w_cmd_vld   = pi1_rdy_o && pi1_op_i == PIRWOP && pi1_addr_i == ADDRBITSZ'(1) && &pi1_sel_i;
  assign w_qsel      = pi1_data_i[2:0];
  assign w_qhi       = |pi1_data_i[ARCHBITSZ-1:3];
  always_comb begin
    w_qry = w_qhi ? '0 :
            w_qsel == QRY_VERSION ? SOCVERSION :
            w_qsel == QRY_CACHESZ ? RAMCACHESZ :
            w_qsel == QRY_RSTO    ? ARCHBITSZ'(rst_o) :
            w_qsel == QRY_PRELDR  ? w_pre :
            w_qsel == QRY_DEVCNT  ? ARCHBITSZ'(DEVCNT) :
            w_qsel == QRY_CORECNT ? ARCHBITSZ'(CORECNT) : '0;
    w_rdata = pi1_op_i == PIRDOP ? (pi1_addr_i < ADDRBITSZ'(NW) ? w_tbl[pi1_addr_i[IW-1:0]] : '0) :
              pi1_addr_i == '0   ? w_qry : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_data <= '0;
    else if (w_rd) r_data <= w_rdata;
`ifdef DEVTBL_PRELDR_EN
  logic r_preldr_dis, r_preldr_o;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_preldr_dis <= 1'b0;
      r_preldr_o   <= 1'b0;
    end else begin
      r_preldr_o   <= w_cmd_vld && pi1_data_i[ARCHBITSZ-1 -: 2] == CMD_PRELDR;
      r_preldr_dis <= r_preldr_dis | (w_cmd_vld && pi1_data_i[ARCHBITSZ-1 -: 2] == CMD_PRELDR);
    end
  assign w_pre    = r_preldr_dis ? '0 : PRELDRADDR;
  assign preldr_o = r_preldr_o;
`else
  assign w_pre    = '0;
  assign preldr_o = 1'b0;
`endif
  devtbl_rstctl #(.CORECNT(CORECNT), .RSTINIT(RSTINIT), .RSTPULSECNT(RSTPULSECNT)) u_rstctl (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_vld  (w_cmd_vld),
    .i_cmd  (pi1_data_i[ARCHBITSZ-1 -: 2]),
    .i_mask (pi1_data_i[CORECNT-1:0]),
    .o_rst  (rst_o),
    .o_busy (w_busy)
  );
endmodule

// File: tb/tb_devtbl_multi.sv
// tb_devtbl_multi: directed and randomized checks of devtbl_multi against a behavioural model
module tb_devtbl_multi;
  import devtbl_pkg::*;
  localparam int N = 16;
  localparam logic [1:0] RI = 2'b10;
  localparam logic [31:0] SOCV = 32'h0002_0001, CACHE = 32'h0000_4000, PRE = 32'h0000_1000;
`ifdef DEVTBL_PRELDR_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  function automatic logic [31:0] tblw(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction
  function automatic logic [319:0] mk_tbl();
    logic [319:0] t;
    t = '0;
    for (int k = 0; k < 10; k++) t[k*32 +: 32] = tblw(k);
    return t;
  endfunction
  localparam logic [319:0] TBL = mk_tbl();

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] rst_o, op = 2'b00;
  logic preldr, rdy;
  logic [29:0] addr = '0, mapsz;
  logic [31:0] din = '0, dout;
  logic [3:0] sel = 4'hF;
  always #5 clk = ~clk;

  devtbl_multi #(.DEVTBLINIT(TBL), .RSTINIT(RI), .RSTPULSECNT(N), .SOCVERSION(SOCV),
                 .RAMCACHESZ(CACHE), .PRELDRADDR(PRE)) dut (
    .clk_i(clk), .rst_i(rst), .rst_o(rst_o), .preldr_o(preldr), .pi1_op_i(op),
    .pi1_addr_i(addr), .pi1_data_i(din), .pi1_data_o(dout), .pi1_sel_i(sel),
    .pi1_rdy_o(rdy), .pi1_mapsz_o(mapsz));

  logic [1:0] m_rst, m_pmask;
  int m_busy;
  logic [31:0] m_data;
  bit m_dis, m_pre;
  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_rst = RI; m_pmask = '0; m_busy = 0; m_data = '0; m_dis = 0; m_pre = 0;
  endtask

  function automatic logic [31:0] query(input logic [31:0] q);
    case (q)
      0: return SOCV;
      1: return CACHE;
      2: return 32'(m_rst);
      3: return (EN && !m_dis) ? PRE : 32'd0;
      4: return 32'd5;
      5: return 32'd2;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [1:0] nrst;
    bit npre;
    if (rst) begin model_reset(); return; end
    nrst = m_rst;
    npre = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) nrst = nrst & ~m_pmask;
    end else if (op == 2'b10) m_data = (addr < 10) ? tblw(int'(addr)) : 32'd0;
    else if (op == 2'b11) begin
      m_data = (addr == 0) ? query(din) : 32'd0;
      if (addr == 1 && sel == 4'hF)
        case (din[31:30])
          2'd0: nrst = nrst | din[1:0];
          2'd1: nrst = nrst & ~din[1:0];
          2'd2: begin nrst = nrst | din[1:0]; m_pmask = din[1:0]; m_busy = N; end
          default: if (EN) begin m_dis = 1; npre = 1; end
        endcase
    end
    m_rst = nrst;
    m_pre = npre;
  endtask

  task automatic compare();
    chk("rst_o", 32'(rst_o), 32'(m_rst));
    chk("rdy_o", 32'(rdy), 32'(m_busy == 0));
    chk("data_o", dout, m_data);
    chk("preldr_o", 32'(preldr), 32'(m_pre));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1 compare();
  endtask

  task automatic req(input logic [1:0] o, input int a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    op = o; addr = 30'(a); din = d; sel = s;
    step();
  endtask

  function automatic logic [31:0] cmdw(input logic [1:0] c, input logic [1:0] m);
    return {c, 28'd0, m};
  endfunction

  int lo, hi;
  initial begin
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    chk("rst_init", 32'(rst_o), 32'h2);
    chk("mapsz", 32'(mapsz), 32'd892);
    for (int a = 0; a < 12; a++) req(2'b10, a, 32'd0);
    req(2'b10, 3, 32'd0);  chk("tbl3", dout, 32'hC0DE_0003);
    req(2'b10, 11, 32'd0); chk("tbl11", dout, 32'd0);
    req(2'b11, 0, 0);      chk("q_ver", dout, 32'h0002_0001);
    req(2'b11, 0, 1);      chk("q_cache", dout, 32'h4000);
    req(2'b11, 0, 4);      chk("q_devcnt", dout, 32'd5);
    req(2'b11, 0, 5);      chk("q_corecnt", dout, 32'd2);
    req(2'b11, 0, 9);      chk("q_other", dout, 32'd0);
    req(2'b01, 0, 4);      chk("wr_hold", dout, 32'd0);
    req(2'b11, 1, cmdw(2'd1, 2'b11));
    req(2'b11, 1, cmdw(2'd0, 2'b10));
    req(2'b11, 0, 2);      chk("q_hold", dout, 32'd2);
    req(2'b11, 1, cmdw(2'd1, 2'b10));
    req(2'b11, 0, 2);      chk("q_rel", dout, 32'd0);
    req(2'b11, 1, cmdw(2'd0, 2'b11), 4'h7);
    chk("sel_ign", 32'(rst_o), 32'd0);
    req(2'b11, 1, cmdw(2'd2, 2'b01));
    lo = 0; hi = 0;
    for (int c = 0; c < 20; c++) begin
      lo += int'(!rdy); hi += int'(rst_o[0]);
      req(2'b10, 3, 32'd0);
    end
    chk("pulse_rdy_lo", 32'(lo), 32'd16);
    chk("pulse_rst_hi", 32'(hi), 32'd16);
    req(2'b11, 0, 3);      chk("q_pre0", dout, EN ? 32'h1000 : 32'd0);
    req(2'b11, 1, cmdw(2'd3, 2'b00));
    chk("preldr_pulse", 32'(preldr), 32'(EN));
    req(2'b11, 0, 3);      chk("q_pre1", dout, 32'd0);
    chk("preldr_drop", 32'(preldr), 32'd0);
    req(2'b11, 1, cmdw(2'd2, 2'b01));
    repeat (4) req(2'b00, 0, 0);
    rst = 1'b1;
    model_reset();
    #1 compare();
    chk("abort_rst", 32'(rst_o), 32'h2);
    chk("abort_rdy", 32'(rdy), 32'd1);
    step();
    rst = 1'b0;
    repeat (20) req(2'b00, 0, 0);
    chk("no_late_rel", 32'(rst_o), 32'h2);
    req(2'b11, 1, cmdw(2'd2, 2'b00));
    lo = 0;
    for (int c = 0; c < 20; c++) begin lo += int'(!rdy); req(2'b00, 0, 0); end
    chk("empty_pulse", 32'(lo), 32'd16);
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] o;
      int a;
      logic [31:0] d;
      o = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 13);
      d = $urandom;
      if (o == 2'b11 && a == 0) d = 32'($urandom_range(0, 9));
      if (o == 2'b11 && a == 1 && $urandom_range(0, 3) != 0) a = 1;
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1 compare();
        step();
        rst = 1'b0;
      end
      req(o, a, d, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
